// File: rtl/pcs_pkg.sv
// Shared constants and types for the 64b/66b PCS transmit path.
package pcs_pkg;

  localparam int PCS_DATA_WIDTH = 64;
  localparam int HDR_WIDTH      = 2;
  localparam int GEARBOX_PERIOD = 33;

  localparam logic [HDR_WIDTH-1:0] SYNC_DATA = 2'b01;
  localparam logic [HDR_WIDTH-1:0] SYNC_CTRL = 2'b10;

  // The header sits in the low bits so that blk[0] is the first bit on the line.
  typedef struct packed {
    logic [PCS_DATA_WIDTH-1:0] payload;
    logic [HDR_WIDTH-1:0]      header;
  } pcs_block_t;

  function automatic logic hdr_illegal(input logic [HDR_WIDTH-1:0] hdr);
    return (hdr != SYNC_DATA) && (hdr != SYNC_CTRL);
  endfunction

endpackage

// File: rtl/gearbox_shift.sv
// Combinational packer: splices a 66-bit block above the 2*seq live residue
// bits and splits the result into the line word and the next residue.
module gearbox_shift
  import pcs_pkg::*;
(
  input  logic [4:0]                i_seq,
  input  pcs_block_t                i_blk,
  input  logic [PCS_DATA_WIDTH-1:0] i_rem,
  output logic [PCS_DATA_WIDTH-1:0] o_word,
  output logic [PCS_DATA_WIDTH-1:0] o_rem
);

  logic [5:0]                  w_shift;
  logic [PCS_DATA_WIDTH-1:0]   w_mask;
  logic [2*PCS_DATA_WIDTH-1:0] w_cat;

  // seq is 0..31 here, so the highest live bit is 62 + 65 = 127.
  assign w_shift = {i_seq, 1'b0};
  assign w_mask  = (64'd1 << w_shift) - 64'd1;
  assign w_cat   = ({62'd0, i_blk} << w_shift) | {64'd0, i_rem & w_mask};

  assign o_word = w_cat[PCS_DATA_WIDTH-1:0];
  assign o_rem  = w_cat[2*PCS_DATA_WIDTH-1:PCS_DATA_WIDTH];

endmodule

// File: rtl/pcs_tx_gearbox.sv
// 66b->64b TX gearbox: 32 blocks in, 33 words out, one drain word per period.
module pcs_tx_gearbox #(
  parameter int PCS_DATA_WIDTH = 64,
  parameter int HDR_WIDTH      = 2,
  parameter int PERIOD         = 33
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [HDR_WIDTH-1:0]      in_header,
  input  logic [PCS_DATA_WIDTH-1:0] in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [PCS_DATA_WIDTH-1:0] out_data,
  output logic                      out_valid,
  output logic                      hdr_err,
  output logic [5:0]                seq
);

  import pcs_pkg::*;

  logic [5:0]                r_seq;
  logic [PCS_DATA_WIDTH-1:0] r_rem;
  logic [PCS_DATA_WIDTH-1:0] r_out_data;
  logic                      r_out_valid;
  logic                      r_hdr_err;

  logic [5:0]                w_seq;
  logic                      w_drain;
  pcs_block_t                w_blk;
  logic [PCS_DATA_WIDTH-1:0] w_word;
  logic [PCS_DATA_WIDTH-1:0] w_rem_next;

  // Phases past the drain slot cannot occur; fold them back to 0 if they do.
  assign w_seq   = (r_seq > 6'(PERIOD - 1)) ? 6'd0 : r_seq;
  assign w_drain = (w_seq == 6'(PERIOD - 1));
  assign in_ready = !w_drain;
  assign w_blk   = '{payload: in_data, header: in_header};

  gearbox_shift u_shift (
    .i_seq  (w_seq[4:0]),
    .i_blk  (w_blk),
    .i_rem  (r_rem),
    .o_word (w_word),
    .o_rem  (w_rem_next)
  );

  // NOTE: state updates use <= so every register samples pre-edge values.
  // NOTE: the residue is cleared on reset so a stale partial word never reaches the line.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_seq       <= '0;
      r_rem       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_hdr_err   <= 1'b0;
    end else if (w_drain) begin
      r_out_data  <= r_rem;
      r_rem       <= '0;
      r_seq       <= '0;
      r_out_valid <= 1'b1;
      r_hdr_err   <= 1'b0;
    end else if (in_valid) begin
      r_out_data  <= w_word;
      r_rem       <= w_rem_next;
      r_seq       <= w_seq + 6'd1;
      r_out_valid <= 1'b1;
      r_hdr_err   <= hdr_illegal(in_header);
    end else begin
      r_seq       <= w_seq;
      r_out_valid <= 1'b0;
      r_hdr_err   <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign hdr_err   = r_hdr_err;
  assign seq       = r_seq;

endmodule

// File: tb/tb_pcs_tx_gearbox.sv
// Directed bench for pcs_tx_gearbox with a bit-level scoreboard of the line stream.
module tb_pcs_tx_gearbox;
  import pcs_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  in_header;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out_data;
  logic        out_valid;
  logic        hdr_err;
  logic [5:0]  seq;

  int checks = 0;
  int errors = 0;
  logic sb_q[$];

  pcs_tx_gearbox dut (
    .clk       (clk),
    .rst       (rst),
    .in_header (in_header),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .hdr_err   (hdr_err),
    .seq       (seq)
  );

  always #5 clk = ~clk;

  task automatic sb_push(input logic [1:0] h, input logic [63:0] d);
    logic [65:0] b;
    b = {d, h};
    for (int i = 0; i < 66; i++) sb_q.push_back(b[i]);
  endtask

  task automatic sb_pop(output logic [63:0] w, output bit ok);
    ok = (sb_q.size() >= 64);
    w  = '0;
    if (ok) for (int i = 0; i < 64; i++) w[i] = sb_q.pop_front();
  endtask

  // Drive one cycle; outputs are observed 1 ns after the rising edge.
  task automatic tick(input logic [1:0] h, input logic [63:0] d, input logic v);
    bit acc;
    in_header = h;
    in_data   = d;
    in_valid  = v;
    acc = v && in_ready && rst;
    @(posedge clk);
    #1;
    if (acc) sb_push(h, d);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(2'b00, 64'd0, 1'b0);
    rst = 1'b1;
    sb_q.delete();
  endtask

  function automatic logic [1:0] rnd_hdr();
    return ($urandom_range(0, 1) != 0) ? SYNC_CTRL : SYNC_DATA;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    tick(SYNC_DATA, 64'hDEAD_BEEF_0000_0001, 1'b1);
    tick(2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 64'd0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    checks++; if (hdr_err !== 1'b0) begin errors++; $display("FAIL reset_hdr_err: got %b want 0", hdr_err); end
    checks++; if (seq !== 6'd0) begin errors++; $display("FAIL reset_seq: got %0d want 0", seq); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    rst = 1'b1;
    sb_q.delete();
  endtask

  task automatic test_single_block();
    do_reset();
    tick(SYNC_DATA, 64'd0, 1'b1);
    checks++; if (out_data !== 64'h0000_0000_0000_0001) begin errors++; $display("FAIL single_data: got %h want 0000000000000001", out_data); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", out_valid); end
    checks++; if (seq !== 6'd1) begin errors++; $display("FAIL single_seq: got %0d want 1", seq); end
    checks++; if (dut.r_rem[1:0] !== 2'b00) begin errors++; $display("FAIL single_rem: got %b want 00", dut.r_rem[1:0]); end
    tick(2'b00, 64'd0, 1'b0);
  endtask

  task automatic test_full_period();
    logic [63:0] w;
    bit ok;
    do_reset();
    for (int i = 0; i < 33; i++) begin
      checks++;
      if (in_ready !== (i != 32)) begin errors++; $display("FAIL period_ready[%0d]: got %b want %b", i, in_ready, (i != 32)); end
      tick(SYNC_CTRL, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      sb_pop(w, ok);
      checks++;
      if (!ok || out_valid !== 1'b1 || out_data !== w) begin errors++; $display("FAIL period_word[%0d]: got %h valid %b want %h", i, out_data, out_valid, w); end
      if (i == 0) begin
        checks++; if (out_data !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL period_first: got %h want FFFFFFFFFFFFFFFE", out_data); end
      end
      if (i == 1) begin
        checks++; if (out_data !== 64'hFFFF_FFFF_FFFF_FFFB) begin errors++; $display("FAIL period_second: got %h want FFFFFFFFFFFFFFFB", out_data); end
      end
    end
    checks++; if (out_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL period_drain: got %h want FFFFFFFFFFFFFFFF", out_data); end
    checks++; if (seq !== 6'd0) begin errors++; $display("FAIL period_seq_wrap: got %0d want 0", seq); end
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL period_leftover: got %0d bits want 0", sb_q.size()); end
    tick(2'b00, 64'd0, 1'b0);
  endtask

  task automatic test_continuous();
    logic [63:0] w;
    bit ok;
    int lows = 0;
    int last_low = -1;
    do_reset();
    for (int i = 0; i < 330; i++) begin
      if (!in_ready) begin
        lows++;
        checks++;
        if ((last_low < 0 && i != 32) || (last_low >= 0 && i - last_low != 33)) begin
          errors++; $display("FAIL cont_ready_spacing: low at cycle %0d, previous %0d, want spacing 33", i, last_low);
        end
        last_low = i;
      end
      tick(rnd_hdr(), {$urandom, $urandom}, 1'b1);
      sb_pop(w, ok);
      checks++;
      if (!ok || out_valid !== 1'b1 || out_data !== w) begin errors++; $display("FAIL cont_word[%0d]: got %h valid %b want %h", i, out_data, out_valid, w); end
    end
    checks++; if (lows != 10) begin errors++; $display("FAIL cont_ready_lows: got %0d want 10", lows); end
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL cont_leftover: got %0d bits want 0", sb_q.size()); end
    tick(2'b00, 64'd0, 1'b0);
  endtask

  task automatic test_bubble();
    logic [63:0] w;
    logic [63:0] prev;
    bit ok;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick(rnd_hdr(), {$urandom, $urandom}, 1'b1);
      sb_pop(w, ok);
      checks++; if (!ok || out_data !== w) begin errors++; $display("FAIL bubble_pre[%0d]: got %h want %h", i, out_data, w); end
    end
    prev = out_data;
    for (int i = 0; i < 3; i++) begin
      tick(SYNC_DATA, 64'hA5A5_A5A5_A5A5_A5A5, 1'b0);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bubble_valid[%0d]: got %b want 0", i, out_valid); end
      checks++; if (seq !== 6'd5) begin errors++; $display("FAIL bubble_seq[%0d]: got %0d want 5", i, seq); end
      checks++; if (out_data !== prev) begin errors++; $display("FAIL bubble_hold[%0d]: got %h want %h", i, out_data, prev); end
    end
    for (int i = 0; i < 28; i++) begin
      tick(rnd_hdr(), {$urandom, $urandom}, 1'b1);
      sb_pop(w, ok);
      checks++; if (!ok || out_valid !== 1'b1 || out_data !== w) begin errors++; $display("FAIL bubble_post[%0d]: got %h want %h", i, out_data, w); end
    end
    checks++; if (seq !== 6'd0 || sb_q.size() != 0) begin errors++; $display("FAIL bubble_end: seq %0d leftover %0d, want 0 and 0", seq, sb_q.size()); end
    tick(2'b00, 64'd0, 1'b0);
  endtask

  task automatic test_hdr_err();
    do_reset();
    tick(2'b11, 64'd0, 1'b1);
    checks++; if (hdr_err !== 1'b1) begin errors++; $display("FAIL hdr11_err: got %b want 1", hdr_err); end
    checks++; if (out_data !== 64'h0000_0000_0000_0003) begin errors++; $display("FAIL hdr11_data: got %h want 0000000000000003", out_data); end
    tick(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    checks++; if (hdr_err !== 1'b1) begin errors++; $display("FAIL hdr00_err: got %b want 1", hdr_err); end
    checks++; if (out_data !== 64'hFFFF_FFFF_FFFF_FFF0) begin errors++; $display("FAIL hdr00_data: got %h want FFFFFFFFFFFFFFF0", out_data); end
    tick(SYNC_DATA, 64'd0, 1'b1);
    checks++; if (hdr_err !== 1'b0) begin errors++; $display("FAIL hdr01_err: got %b want 0", hdr_err); end
    checks++; if (out_data !== 64'h0000_0000_0000_001F) begin errors++; $display("FAIL hdr01_data: got %h want 000000000000001F", out_data); end
    tick(2'b11, 64'd0, 1'b0);
    checks++; if (hdr_err !== 1'b0) begin errors++; $display("FAIL hdr_idle_err: got %b want 0", hdr_err); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 17; i++) tick(rnd_hdr(), {$urandom, $urandom}, 1'b1);
    checks++; if (seq !== 6'd17) begin errors++; $display("FAIL mid_seq_pre: got %0d want 17", seq); end
    rst = 1'b0;
    tick(SYNC_DATA, 64'h1234_5678_9ABC_DEF0, 1'b1);
    checks++; if (out_valid !== 1'b0 || out_data !== 64'd0 || hdr_err !== 1'b0) begin
      errors++; $display("FAIL mid_outputs: valid %b data %h err %b, want 0 0 0", out_valid, out_data, hdr_err);
    end
    checks++; if (seq !== 6'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL mid_seq: seq %0d ready %b, want 0 1", seq, in_ready); end
    rst = 1'b1;
    sb_q.delete();
    tick(SYNC_DATA, 64'd0, 1'b1);
    checks++; if (out_data !== 64'h0000_0000_0000_0001 || seq !== 6'd1) begin
      errors++; $display("FAIL mid_after: data %h seq %0d, want 0000000000000001 1", out_data, seq);
    end
    tick(2'b00, 64'd0, 1'b0);
  endtask

  task automatic test_drain_hold();
    logic [63:0] w;
    bit ok;
    do_reset();
    for (int i = 0; i < 32; i++) begin
      tick(rnd_hdr(), {$urandom, $urandom}, 1'b1);
      sb_pop(w, ok);
      checks++; if (!ok || out_data !== w) begin errors++; $display("FAIL drain_fill[%0d]: got %h want %h", i, out_data, w); end
    end
    checks++; if (seq !== 6'd32 || in_ready !== 1'b0) begin errors++; $display("FAIL drain_phase: seq %0d ready %b, want 32 0", seq, in_ready); end
    tick(SYNC_CTRL, 64'h0123_4567_89AB_CDEF, 1'b1);
    sb_pop(w, ok);
    checks++; if (!ok || out_valid !== 1'b1 || out_data !== w) begin errors++; $display("FAIL drain_word: got %h want %h", out_data, w); end
    checks++; if (seq !== 6'd0 || sb_q.size() != 0) begin errors++; $display("FAIL drain_not_consumed: seq %0d leftover %0d, want 0 0", seq, sb_q.size()); end
    tick(SYNC_CTRL, 64'h0123_4567_89AB_CDEF, 1'b1);
    checks++; if (out_data !== 64'h048D_159E_26AF_37BE || seq !== 6'd1) begin
      errors++; $display("FAIL drain_held_block: data %h seq %0d, want 048D159E26AF37BE 1", out_data, seq);
    end
    tick(2'b00, 64'd0, 1'b0);
  endtask

  initial begin
    rst       = 1'b0;
    in_header = 2'b00;
    in_data   = 64'd0;
    in_valid  = 1'b0;
    test_reset();
    test_single_block();
    test_full_period();
    test_continuous();
    test_bubble();
    test_hdr_err();
    test_reset_mid();
    test_drain_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
